// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - parameterised serial pattern detector with overlap control and saturating match counter
module seq_det_param #(
  parameter int          N       = 4,
  parameter int          CNT_W   = 8,
  parameter logic [N-1:0] RST_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_cnt,
  output logic             detect,
  output logic             detect_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [N-1:0]      pat;
  logic [N-2:0]      hist;
  logic [FILL_W-1:0] fill;

  logic [N-1:0]      pat_nxt;
  logic [N-2:0]      hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Window of the last N-1 history bits with the current bit appended (LSB newest).
  logic [N-1:0]      window;
  assign window = {hist, din};

  // Mealy match: only a fully filled window on a non-load beat can match.
  assign detect = din_valid & ~pat_load & (fill == FILL_MAX) & (window == pat);

  assign cnt_sat = (match_cnt == CNT_MAX);

  // Next-state for pattern, history and fill counter.
  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    if (pat_load) begin
      // A new pattern restarts detection from an empty window; din is dropped.
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (detect && !overlap) begin
      // Non-overlapping mode: the matched bits cannot seed the next match.
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (din_valid) begin
      hist_nxt = window[N-2:0];
      if (fill != FILL_MAX) begin
        fill_nxt = fill + 1'b1;
      end
    end
  end

  // Next-state for the match counter: clear wins over a same-cycle detect.
  always_comb begin
    cnt_nxt = match_cnt;
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if (detect && (match_cnt != CNT_MAX)) begin
      cnt_nxt = match_cnt + 1'b1;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= RST_PAT;
      hist <= '0;
      fill <= '0;
    end else begin
      pat  <= pat_nxt;
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  // Match counter and registered detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
      detect_q  <= 1'b0;
    end else begin
      match_cnt <= cnt_nxt;
      detect_q  <= detect;
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - scoreboard bench for seq_det_param (CNT_W=8 and CNT_W=2 instances)
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_cnt = 1'b0;

  logic       detect8, detect_q8, cnt_sat8;
  logic [7:0] match_cnt8;
  logic       detect2, detect_q2, cnt_sat2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       det;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];

  seq_det_param #(.N(4), .CNT_W(8), .RST_PAT(4'b1011)) dut8 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .detect(detect8), .detect_q(detect_q8), .match_cnt(match_cnt8), .cnt_sat(cnt_sat8)
  );

  seq_det_param #(.N(4), .CNT_W(2), .RST_PAT(4'b1011)) dut2 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .detect(detect2), .detect_q(detect_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One driven cycle; anything the DUT responds to gets an expected record.
  task automatic drive(input logic v, input logic d, input logic ld, input logic [3:0] pin,
                       input logic clr, input logic edet, input logic [7:0] ecnt);
    exp_t r;
    din_valid = v;
    din       = d;
    pat_load  = ld;
    pat_in    = pin;
    clr_cnt   = clr;
    if (v || ld || clr) begin
      r.det = edet;
      r.cnt = ecnt;
      sbq.push_back(r);
    end
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    pat_load  = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic beat(input logic d, input logic edet, input logic [7:0] ecnt);
    drive(1'b1, d, 1'b0, 4'b0000, 1'b0, edet, ecnt);
  endtask

  task automatic load(input logic [3:0] pin, input logic [7:0] ecnt);
    drive(1'b1, 1'b1, 1'b1, pin, 1'b0, 1'b0, ecnt);
  endtask

  task automatic idle(input logic d);
    drive(1'b0, d, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0);
  endtask

  // Monitor: pops one record per presented beat/load/clear and checks both instances.
  initial begin
    exp_t r;
    int   c2;
    forever begin
      @(negedge clk);
      if (reset && (din_valid || pat_load || clr_cnt)) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          r  = sbq.pop_front();
          c2 = (r.cnt > 8'd3) ? 3 : int'(r.cnt);
          chk("detect8", int'(detect8), int'(r.det));
          chk("detect2", int'(detect2), int'(r.det));
          @(posedge clk);
          #1;
          chk("detect_q8", int'(detect_q8), int'(r.det));
          chk("detect_q2", int'(detect_q2), int'(r.det));
          chk("match_cnt8", int'(match_cnt8), int'(r.cnt));
          chk("match_cnt2", int'(match_cnt2), c2);
          chk("cnt_sat8", int'(cnt_sat8), int'(r.cnt == 8'd255));
          chk("cnt_sat2", int'(cnt_sat2), int'(c2 == 3));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with active-looking inputs.
    din_valid = 1'b1;
    din       = 1'b1;
    #3;
    chk("rst_detect", int'(detect8), 0);
    chk("rst_detect_q", int'(detect_q8), 0);
    chk("rst_cnt", int'(match_cnt8), 0);
    chk("rst_sat2", int'(cnt_sat2), 0);
    din_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Overlapping: 1,0,1,1,0,1,1 -> detects on beats 4 and 7.
    overlap = 1'b1;
    beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 1, 1);
    beat(0, 0, 1); beat(1, 0, 1); beat(1, 1, 2);
    load(4'b1011, 2);

    // Non-overlapping: same beats -> detect on beat 4 only.
    overlap = 1'b0;
    beat(1, 0, 2); beat(0, 0, 2); beat(1, 0, 2); beat(1, 1, 3);
    beat(0, 0, 3); beat(1, 0, 3); beat(1, 0, 3);
    load(4'b1011, 3);

    // Idle cycles with din=1 between beats do not shift history.
    overlap = 1'b1;
    beat(1, 0, 3); beat(0, 0, 3); beat(1, 0, 3);
    idle(1); idle(1); idle(1);
    beat(1, 1, 4);
    load(4'b1011, 4);

    // Pattern reload mid-sequence: load drops din and restarts the window.
    beat(1, 0, 4); beat(0, 0, 4); beat(1, 0, 4);
    load(4'b0110, 4);
    beat(1, 0, 4);
    beat(0, 0, 4); beat(1, 0, 4); beat(1, 0, 4); beat(0, 1, 5);

    // Asynchronous reset mid-cycle restores RST_PAT and clears state.
    beat(1, 0, 5); beat(0, 0, 5); beat(1, 0, 5);
    chk("fill_before_rst", int'(dut8.fill), 3);
    #2;
    din_valid = 1'b1;
    din       = 1'b1;
    reset     = 1'b0;
    #1;
    chk("async_detect_q", int'(detect_q8), 0);
    chk("async_cnt", int'(match_cnt8), 0);
    chk("async_fill", int'(dut8.fill), 0);
    chk("async_pat", int'(dut8.pat), 4'b1011);
    chk("async_detect", int'(detect8), 0);
    din_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 1, 1);

    // Saturation of the 2-bit counter, then clear beating a same-cycle detect.
    beat(0, 0, 1); beat(1, 0, 1); beat(1, 1, 2);
    beat(0, 0, 2); beat(1, 0, 2); beat(1, 1, 3);
    beat(0, 0, 3); beat(1, 0, 3); beat(1, 1, 4);
    beat(0, 0, 4); beat(1, 0, 4); beat(1, 1, 5);
    beat(0, 0, 5); beat(1, 0, 5);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 0);
    beat(0, 0, 0); beat(1, 0, 0); beat(1, 1, 1);

    idle(0); idle(0); idle(0);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter N, default 4, pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, match counter width; legal range 1..16.
REQ-003 SHALL have parameter RST_PAT, default 4'b1011 (N bits), pattern loaded at reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din_valid  input  1  qualifies din; a cycle with din_valid=1 is a "beat".
REQ-007 SHALL have port din  input  1  serial data bit, sampled only on beats.
REQ-008 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port pat_load  input  1  one-cycle strobe to load pat_in as the new pattern.
REQ-010 SHALL have port pat_in  input  N  new pattern; MSB is compared against the oldest bit.
REQ-011 SHALL have port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port detect  output  1  Mealy match flag, combinational from state and current inputs.
REQ-013 SHALL have port detect_q  output  1  detect registered one cycle.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating count of detects.
REQ-015 SHALL have port cnt_sat  output  1  high while match_cnt equals 2^CNT_W-1.

Function
REQ-016 SHALL hold pattern register pat[N-1:0], history hist[N-2:0] (LSB newest), and fill counter fill (0..N-1).
REQ-017 SHALL drive detect = din_valid & ~pat_load & (fill==N-1) & ({hist,din}==pat), with no additional gating.
REQ-018 SHALL, on a beat without pat_load, shift din into hist LSB and increment fill, saturating at N-1.
REQ-019 SHALL, when detect=1 and overlap=0, clear hist and set fill=0 in that cycle instead of REQ-018.
REQ-020 SHALL, when detect=1 and overlap=1, apply REQ-018 unchanged so suffix bits count toward the next match.
REQ-021 SHALL leave hist, fill, and pat unchanged on cycles with din_valid=0 and pat_load=0.
REQ-022 SHALL, on pat_load=1, load pat<=pat_in, clear hist and fill, ignore din that cycle, and keep detect=0; match_cnt is unaffected.
REQ-023 SHALL sample overlap every cycle; a change takes effect on the next detect evaluated.
REQ-024 SHALL increment match_cnt by 1 on each cycle with detect=1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL, when clr_cnt=1, set match_cnt to 0, taking priority over a simultaneous detect (result 0, not 1).
REQ-026 SHALL drive cnt_sat combinationally from match_cnt.
REQ-027 SHALL register detect_q<=detect every cycle.
REQ-028 SHALL give detect zero-cycle latency from the completing beat and give detect_q one-cycle latency.

Reset
REQ-029 SHALL, while reset=0, force pat=RST_PAT, hist=0, fill=0, match_cnt=0, and detect_q=0, regardless of clk.
REQ-030 SHALL force detect=0 while reset=0.
REQ-031 SHALL resume on the first rising edge after reset deasserts, with no pattern match possible until N fresh beats have arrived.

Verification (N=4, CNT_W=8, RST_PAT=1011 unless stated)
REQ-032 SHALL cover: overlap=1, beats 1,0,1,1,0,1,1 -> detect on beats 4 and 7; match_cnt=2.
REQ-033 SHALL cover: overlap=0, same beats -> detect on beat 4 only; match_cnt=1.
REQ-034 SHALL cover: beats 1,0,1 with 3 idle cycles between (din=1 while idle), then 1 -> detect only on the 4th beat; detect_q high next cycle.
REQ-035 SHALL cover: beats 1,0,1, then pat_load with pat_in=0110, then beats 1 and 0,1,1,0 -> no detect on the beat 1; detect on the final 0; match_cnt unchanged by the load.
REQ-036 SHALL cover: CNT_W=2, five separate matches -> match_cnt=3 and cnt_sat=1; then clr_cnt coincident with a detect -> match_cnt=0 and cnt_sat=0.
REQ-037 SHALL cover: after beats 1,0,1, assert reset=0 mid-cycle -> detect_q, match_cnt, and fill are 0 immediately and pat=1011; after release, beat 1 gives no detect.
